seg_twos_frame_decoder: RTL and testbench



---
 rtl/seg_twos_frame_decoder.sv | 140 ++++++++++++++
 tb/tb_seg_twos_frame_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_twos_frame_decoder.sv
// seg_twos_frame_decoder: serial 14-bit active-low 7-segment frame -> 4-bit
// two's-complement value. The frame is {a..g} magnitude digit, then {h..n} sign.
// Optional build macro SEG_DECODER_STICKY_ERR_EN: adds err_clr and makes err a
// sticky level instead of a one-cycle pulse.
module seg_twos_frame_decoder #(
  parameter int TIMEOUT    = 16,
  parameter int FRAME_BITS = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       bit_in,
  input  logic       bit_valid,
`ifdef SEG_DECODER_STICKY_ERR_EN
  input  logic       err_clr,
`endif
  output logic [3:0] value,
  output logic       out_valid,
  output logic       err,
  output logic       busy
);

  if (FRAME_BITS != 14) begin : g_bad_frame_bits
    $error("seg_twos_frame_decoder: FRAME_BITS must be 14");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("seg_twos_frame_decoder: TIMEOUT must be at least 2");
  end

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } dec_t;

  state_t          state;
  logic [13:0]     frame;   // shifts right; first bit (segment a) ends in frame[0]
  logic [3:0]      cnt;
  logic [TW-1:0]   tcnt;

  logic [6:0]      mag_pat, sgn_pat;
  logic [3:0]      mag;
  logic            mag_ok, sgn_pos, sgn_neg;
  dec_t            dec;
  logic            start, decode_fire, timeout_fire, err_set;

  // frame[0] is segment a; patterns are written a..g / h..n left to right
  assign mag_pat = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5], frame[6]};
  assign sgn_pat = {frame[7], frame[8], frame[9], frame[10], frame[11], frame[12], frame[13]};

  // Segment pattern to magnitude lookup
  always_comb begin
    mag    = 4'd0;
    mag_ok = 1'b1;
    case (mag_pat)
      7'b0000001: mag = 4'd0;
      7'b1001111: mag = 4'd1;
      7'b0010010: mag = 4'd2;
      7'b0000110: mag = 4'd3;
      7'b1001100: mag = 4'd4;
      7'b0100100: mag = 4'd5;
      7'b0100000: mag = 4'd6;
      7'b0001111: mag = 4'd7;
      7'b0000000: mag = 4'd8;
      default:    mag_ok = 1'b0;
    endcase
  end

  assign sgn_pos = (sgn_pat == 7'b1111111);
  assign sgn_neg = (sgn_pat == 7'b1111110);

  // +8 and -0 have no 4-bit two's-complement meaning here, so both are errors
  assign dec.ok  = mag_ok && ((sgn_pos && (mag <= 4'd7)) || (sgn_neg && (mag != 4'd0)));
  assign dec.val = sgn_neg ? (4'd0 - mag) : mag;

  assign start        = bit_valid && frame_start;
  assign decode_fire  = (state == DECODE);
  assign timeout_fire = (state == SHIFT) && !bit_valid && (tcnt == TW'(TIMEOUT - 1));
  assign err_set      = (decode_fire && !dec.ok) || timeout_fire;
  assign busy         = (state == SHIFT);

  // Frame capture FSM: start/restart has priority over normal shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      frame <= '0;
      cnt   <= '0;
      tcnt  <= '0;
    end else if (start) begin
      state <= SHIFT;
      frame <= {bit_in, 13'd0};
      cnt   <= 4'd1;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: ;
        SHIFT: begin
          if (bit_valid) begin
            frame <= {bit_in, frame[13:1]};
            cnt   <= cnt + 4'd1;
            tcnt  <= '0;
            if (cnt == 4'd13) state <= DECODE;
          end else if (timeout_fire) begin
            state <= IDLE;
            cnt   <= '0;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DECODE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered result: value only moves with out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= 4'b0000;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= decode_fire && dec.ok;
      if (decode_fire && dec.ok) value <= dec.val;
`ifdef SEG_DECODER_STICKY_ERR_EN
      err <= err_set || (err && !err_clr);
`else
      err <= err_set;
`endif
    end
  end

endmodule

// File: tb/tb_seg_twos_frame_decoder.sv
// Scoreboard bench for seg_twos_frame_decoder: expected outcomes are queued as
// frames are driven and popped when the DUT pulses out_valid or err.
module tb_seg_twos_frame_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
`ifdef SEG_DECODER_STICKY_ERR_EN
  logic       err_clr = 1'b0;
`endif
  logic [3:0] value;
  logic       out_valid, err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         is_err;
    logic [3:0] val;
  } exp_t;

  exp_t       q[$];
  logic [3:0] last_val = 4'd0;
  bit         err_q = 1'b0;

  localparam logic [6:0] PATS [9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000};

  seg_twos_frame_decoder #(.TIMEOUT(16), .FRAME_BITS(14)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid),
`ifdef SEG_DECODER_STICKY_ERR_EN
    .err_clr(err_clr),
`endif
    .value(value), .out_valid(out_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [13:0] f);
    exp_t e;
    int   m = -1;
    for (int i = 0; i < 9; i++) if (PATS[i] == f[13:7]) m = i;
    e.is_err = 1'b1;
    e.val    = 4'd0;
    if (m >= 0 && f[6:0] == 7'b1111111 && m <= 7) begin
      e.is_err = 1'b0; e.val = 4'(m);
    end else if (m >= 1 && f[6:0] == 7'b1111110) begin
      e.is_err = 1'b0; e.val = 4'(16 - m);
    end
    return e;
  endfunction

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin : mon
    exp_t e;
    bit   ev_err;
    if (rst_n) begin
`ifdef SEG_DECODER_STICKY_ERR_EN
      ev_err = err && !err_q;
`else
      ev_err = err;
      if (out_valid) chk("excl", err, 1'b0);
`endif
      if (out_valid || ev_err) begin
        if (q.size() == 0) chk("unexpected_pulse", {out_valid, ev_err}, 2'b00);
        else begin
          e = q.pop_front();
          chk("kind_err", ev_err, e.is_err);
          chk("value", value, e.is_err ? last_val : e.val);
          if (!e.is_err) last_val = e.val;
        end
      end
      err_q = err;
    end else err_q = 1'b0;
  end

  task automatic send_bit(bit b, bit fs, int gap);
    bit_in = b; bit_valid = 1'b1; frame_start = fs;
    @(posedge clk); #1;
    bit_valid = 1'b0; frame_start = 1'b0;
    if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
  endtask

  task automatic send_frame(logic [13:0] f, int gap);
    for (int i = 0; i < 14; i++) send_bit(f[13-i], i == 0, gap);
  endtask

  task automatic exp_frame(logic [13:0] f);
    q.push_back(model(f));
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.val = 4'd0;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic clr_err();
`ifdef SEG_DECODER_STICKY_ERR_EN
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    logic [13:0] f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_value", value, 4'd0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // -3, with exact latency check
    f = 14'b0000110_1111110;
    exp_frame(f);
    send_frame(f, 0);
    chk("busy_decode", busy, 1'b0);
    chk("lat_ov_early", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_ov", out_valid, 1'b1);
    chk("lat_val", value, 4'b1101);
    drain();

    // -8, then +8 (error, value holds)
    f = 14'b0000000_1111110; exp_frame(f); send_frame(f, 0); drain();
    f = 14'b0000000_1111111; exp_frame(f); send_frame(f, 0); drain();
    chk("hold_after_err", value, 4'b1000);
    clr_err();

    // +1 with 3-cycle gaps
    f = 14'b1001111_1111111; exp_frame(f); send_frame(f, 3); drain();

    // Timeout: 16 idle cycles after bit 5; later bits are ignored
    push_err();
    for (int i = 0; i < 14; i++) begin
      send_bit(f[13-i], i == 0, (i == 5) ? 16 : 0);
      if (i == 5) chk("busy_after_timeout", busy, 1'b0);
    end
    drain();
    chk("value_after_timeout", value, 4'b0001);
    clr_err();

    // 15 idle cycles is still inside the budget
    f = 14'b0100000_1111110; exp_frame(f);
    for (int i = 0; i < 14; i++) send_bit(f[13-i], i == 0, (i == 5) ? 15 : 0);
    drain();

    // Restart at bit 7
    f = 14'b1001100_1111111;
    for (int i = 0; i < 7; i++) send_bit(f[13-i], i == 0, 0);
    f = 14'b0001111_1111111; exp_frame(f); send_frame(f, 0); drain();
    chk("restart_val", value, 4'b0111);

    // Reset at bit 10
    f = 14'b0100100_1111111;
    for (int i = 0; i < 10; i++) send_bit(f[13-i], i == 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_value", value, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    last_val = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 10; i < 14; i++) send_bit(f[13-i], 1'b0, 0);
    chk("idle_busy", busy, 1'b0);
    drain();

    // Bad sign, then a good frame
    f = 14'b0010010_0111111; exp_frame(f); send_frame(f, 0); drain();
    f = 14'b0100100_1111111; exp_frame(f); send_frame(f, 0); drain();
`ifdef SEG_DECODER_STICKY_ERR_EN
    chk("sticky_held", err, 1'b1);
    clr_err();
    chk("sticky_clr", err, 1'b0);
`else
    chk("err_pulse_gone", err, 1'b0);
`endif
    chk("final_val", value, 4'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
